// File: rtl/kamacore_pkg.sv
// Shared definitions for the kamacore branch path: widths, B-type encodings
// and the branch controller state enum.
package kamacore_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [6:0] OPCODE_SB_TYPE = 7'b1100011;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } branch_ctrl_state_t;

endpackage

// File: rtl/kamacore_branching_unit.sv
// Combinational branch evaluator: decides taken/not-taken for a B-type
// instruction and extracts its sign-extended byte offset.
module kamacore_branching_unit
    import kamacore_pkg::*;
#(
    parameter int CPU_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic [CPU_WIDTH-1:0]  instruction,
    input  logic [CPU_WIDTH-1:0]  source1,
    input  logic [CPU_WIDTH-1:0]  source2,
    output logic                  branch_valid,
    output logic [ADDR_WIDTH-1:0] branch_offset
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [12:0] imm;
    logic        is_eq;
    logic        is_lt;
    logic        is_ltu;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign imm    = {instruction[31], instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};

    assign branch_offset = {{(ADDR_WIDTH-13){imm[12]}}, imm};

    assign is_eq  = (source1 == source2);
    assign is_lt  = ($signed(source1) < $signed(source2));
    assign is_ltu = (source1 < source2);

    // Unknown funct3 values fall through to not-taken.
    always_comb begin
        branch_valid = 1'b0;
        if (opcode == OPCODE_SB_TYPE) begin
            case (funct3)
                FUNCT3_BEQ:  branch_valid = is_eq;
                FUNCT3_BNE:  branch_valid = !is_eq;
                FUNCT3_BLT:  branch_valid = is_lt;
                FUNCT3_BGE:  branch_valid = !is_lt;
                FUNCT3_BLTU: branch_valid = is_ltu;
                FUNCT3_BGEU: branch_valid = !is_ltu;
                default:     branch_valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/kamacore_branch_controller.sv
// Branch resolution sequencer: accepts a request, evaluates it, redirects
// fetch on taken branches, holds flush, and keeps outcome statistics.
//
// state    | meaning
// IDLE     | ready for a new branch request
// EVAL     | latched request evaluated, resolve pulse, target registered
// REDIRECT | redirect offered to fetch, flush asserted
// FLUSH    | post-redirect flush hold, counting down
module kamacore_branch_controller
    import kamacore_pkg::*;
#(
    parameter int CPU_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    input  logic [CPU_WIDTH-1:0]  req_instruction,
    input  logic [CPU_WIDTH-1:0]  req_source1,
    input  logic [CPU_WIDTH-1:0]  req_source2,
    output logic                  resolve_valid,
    output logic                  resolve_taken,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  stall,
    input  logic                  count_clear,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [CNT_WIDTH-1:0]  resolved_count
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? FLUSH_W'(FLUSH_CYCLES - 1) : '0;

    branch_ctrl_state_t state;
    branch_ctrl_state_t state_next;

    logic [ADDR_WIDTH-1:0] lat_pc;
    logic [CPU_WIDTH-1:0]  lat_instruction;
    logic [CPU_WIDTH-1:0]  lat_source1;
    logic [CPU_WIDTH-1:0]  lat_source2;
    logic [ADDR_WIDTH-1:0] target;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_offset;

    kamacore_branching_unit #(
        .CPU_WIDTH  (CPU_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_branching_unit (
        .instruction   (lat_instruction),
        .source1       (lat_source1),
        .source2       (lat_source2),
        .branch_valid  (branch_valid),
        .branch_offset (branch_offset)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_valid) state_next = EVAL;
            EVAL:     state_next = branch_valid ? REDIRECT : IDLE;
            REDIRECT: if (redirect_ready) state_next = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
            FLUSH:    if (flush_cnt == '0) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state == IDLE);
        resolve_valid  = (state == EVAL);
        resolve_taken  = (state == EVAL) && branch_valid;
        redirect_valid = (state == REDIRECT);
        redirect_pc    = (state == REDIRECT) ? target : '0;
        flush          = (state == REDIRECT) || (state == FLUSH);
        stall          = (state != IDLE);
    end

    // Request fields are captured once so the requester may change them after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_pc          <= '0;
            lat_instruction <= '0;
            lat_source1     <= '0;
            lat_source2     <= '0;
            target          <= '0;
            flush_cnt       <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_pc          <= req_pc;
                lat_instruction <= req_instruction;
                lat_source1     <= req_source1;
                lat_source2     <= req_source2;
            end
            if (state == EVAL) begin
                target <= lat_pc + branch_offset;
            end
            if (state == REDIRECT && redirect_ready) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_count    <= '0;
            resolved_count <= '0;
        end else if (count_clear) begin
            taken_count    <= '0;
            resolved_count <= '0;
        end else if (state == EVAL) begin
            resolved_count <= resolved_count + 1'b1;
            if (branch_valid) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kamacore_branch_controller.sv
// Randomized self-checking bench for kamacore_branch_controller against a
// behavioural branch-resolution model.
module tb_kamacore_branch_controller;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_instruction;
    logic [31:0] req_source1;
    logic [31:0] req_source2;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        stall;
    logic        count_clear;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] resolved_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mdl_taken = 0;
    int mdl_resolved = 0;

    always #5 clk = ~clk;

    kamacore_branch_controller #(
        .CPU_WIDTH    (32),
        .ADDR_WIDTH   (32),
        .FLUSH_CYCLES (2),
        .CNT_WIDTH    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .req_instruction (req_instruction),
        .req_source1     (req_source1),
        .req_source2     (req_source2),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .redirect_valid  (redirect_valid),
        .redirect_ready  (redirect_ready),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .stall           (stall),
        .count_clear     (count_clear),
        .taken_count     (taken_count),
        .resolved_count  (resolved_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch outcome from the RISC-V conditional-branch rules.
    function automatic bit mdl_is_taken(input logic [31:0] inst, input logic [31:0] a,
                                        input logic [31:0] b);
        int signed sa;
        int signed sb;
        longint ua;
        longint ub;
        sa = a;
        sb = b;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (inst[6:0] != 7'h63) return 1'b0;
        case (inst[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_target(input logic [31:0] pc, input logic [31:0] inst);
        int off;
        off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048;
        if (inst[31]) off = off - 4096;
        return pc + 32'(off);
    endfunction

    task automatic run_branch(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input int ready_delay, input bit clear_eval);
        bit          exp_taken;
        logic [31:0] exp_tgt;
        exp_taken = mdl_is_taken(inst, s1, s2);
        exp_tgt   = mdl_target(pc, inst);

        total_cnt++; if (req_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", req_ready); else pass_cnt++;
        req_valid = 1'b1; req_pc = pc; req_instruction = inst; req_source1 = s1; req_source2 = s2;
        tick();
        req_valid = 1'b0;
        req_pc = $urandom; req_instruction = $urandom; req_source1 = $urandom; req_source2 = $urandom;
        count_clear = clear_eval;
        total_cnt++; if (resolve_valid !== 1'b1) $display("FAIL resolve_valid got %b exp 1", resolve_valid); else pass_cnt++;
        total_cnt++; if (resolve_taken !== exp_taken) $display("FAIL resolve_taken inst=%h s1=%h s2=%h got %b exp %b", inst, s1, s2, resolve_taken, exp_taken); else pass_cnt++;
        total_cnt++; if (stall !== 1'b1 || req_ready !== 1'b0) $display("FAIL eval_busy stall=%b ready=%b exp 1/0", stall, req_ready); else pass_cnt++;
        tick();
        count_clear = 1'b0;
        if (clear_eval) begin
            mdl_taken = 0; mdl_resolved = 0;
        end else begin
            mdl_resolved = (mdl_resolved + 1) % CNT_MOD;
            if (exp_taken) mdl_taken = (mdl_taken + 1) % CNT_MOD;
        end
        total_cnt++; if (resolved_count !== CNT_W'(mdl_resolved)) $display("FAIL resolved_count got %0d exp %0d", resolved_count, mdl_resolved); else pass_cnt++;
        total_cnt++; if (taken_count !== CNT_W'(mdl_taken)) $display("FAIL taken_count got %0d exp %0d", taken_count, mdl_taken); else pass_cnt++;
        total_cnt++; if (resolve_valid !== 1'b0) $display("FAIL resolve_pulse got %b exp 0", resolve_valid); else pass_cnt++;
        if (!exp_taken) begin
            total_cnt++; if (req_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0 || stall !== 1'b0)
                $display("FAIL nt_idle ready=%b rv=%b flush=%b stall=%b exp 1/0/0/0", req_ready, redirect_valid, flush, stall);
            else pass_cnt++;
            return;
        end
        for (int i = 0; i < ready_delay; i++) begin
            total_cnt++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== exp_tgt)
                $display("FAIL redirect_hold rv=%b flush=%b pc=%h exp 1/1/%h", redirect_valid, flush, redirect_pc, exp_tgt);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_tgt)
            $display("FAIL redirect_pc rv=%b pc=%h exp 1/%h", redirect_valid, redirect_pc, exp_tgt);
        else pass_cnt++;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++; if (flush !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || req_ready !== 1'b0)
                $display("FAIL flush_hold cyc=%0d flush=%b rv=%b pc=%h ready=%b exp 1/0/0/0", i, flush, redirect_valid, redirect_pc, req_ready);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (flush !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0)
            $display("FAIL flush_end flush=%b ready=%b stall=%b exp 0/1/0", flush, req_ready, stall);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_pc = 0; req_instruction = 0; req_source1 = 0; req_source2 = 0;
        redirect_ready = 0; count_clear = 0;
        #23;
        total_cnt++; if (req_ready !== 1'b1 || resolve_valid !== 0 || resolve_taken !== 0 || redirect_valid !== 0 ||
                        redirect_pc !== 0 || flush !== 0 || stall !== 0 || taken_count !== 0 || resolved_count !== 0)
            $display("FAIL reset_outputs ready=%b rv=%b rt=%b rdv=%b pc=%h fl=%b st=%b tc=%0d rc=%0d exp ready=1 rest 0",
                     req_ready, resolve_valid, resolve_taken, redirect_valid, redirect_pc, flush, stall, taken_count, resolved_count);
        else pass_cnt++;
        rst = 1'b0;
        mdl_taken = 0; mdl_resolved = 0;
        tick();
    endtask

    task automatic test_taken_beq();
        run_branch(32'h100, 32'h00000463, 32'd5, 32'd5, 3, 1'b0);
    endtask

    task automatic test_not_taken_bne();
        run_branch(32'h200, 32'h00001463, 32'd7, 32'd7, 0, 1'b0);
    endtask

    task automatic test_signed_unsigned();
        run_branch(32'h4, 32'hFE004C63, 32'hFFFFFFFF, 32'd1, 1, 1'b0);
        run_branch(32'h4, 32'hFE006C63, 32'hFFFFFFFF, 32'd1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] inst, s1, s2;
        for (int n = 0; n < 60; n++) begin
            inst = $urandom;
            if ($urandom_range(7) != 0) inst[6:0] = 7'h63;
            s1 = $urandom;
            case ($urandom_range(3))
                0: s2 = s1;
                1: s2 = 32'($urandom_range(4)) - 32'd2;
                default: s2 = $urandom;
            endcase
            if ($urandom_range(3) == 0) s1 = 32'($urandom_range(4)) - 32'd2;
            run_branch($urandom, inst, s1, s2, int'($urandom_range(3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        req_valid = 1'b1; req_pc = 32'h40; req_instruction = 32'h00001463;
        req_source1 = 32'd9; req_source2 = 32'd9;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (req_ready !== ((i % 2) == 0)) $display("FAIL b2b_ready cyc=%0d got %b exp %b", i, req_ready, (i % 2) == 0); else pass_cnt++;
            if (req_ready) accepts++;
            tick();
        end
        req_valid = 1'b0;
        mdl_resolved = (mdl_resolved + accepts) % CNT_MOD;
        total_cnt++; if (accepts !== 4) $display("FAIL b2b_accepts got %0d exp 4", accepts); else pass_cnt++;
        total_cnt++; if (resolved_count !== CNT_W'(mdl_resolved)) $display("FAIL b2b_resolved got %0d exp %0d", resolved_count, mdl_resolved); else pass_cnt++;
    endtask

    task automatic test_flush_block();
        int busy = 0;
        req_valid = 1'b1; req_pc = 32'h300; req_instruction = 32'h00000463;
        req_source1 = 32'd1; req_source2 = 32'd1;
        tick();
        req_instruction = 32'h00001463;
        tick();
        mdl_resolved = (mdl_resolved + 1) % CNT_MOD; mdl_taken = (mdl_taken + 1) % CNT_MOD;
        redirect_ready = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            redirect_ready = 1'b1;
            busy++;
            if (resolve_valid) $display("FAIL flush_block_resolve got 1 exp 0 cyc=%0d", i);
            tick();
        end
        redirect_ready = 1'b0;
        total_cnt++; if (busy !== 3) $display("FAIL flush_block_busy got %0d exp 3", busy); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if (resolve_valid !== 1'b1 || resolve_taken !== 1'b0)
            $display("FAIL flush_block_accept rv=%b rt=%b exp 1/0", resolve_valid, resolve_taken);
        else pass_cnt++;
        tick();
        mdl_resolved = (mdl_resolved + 1) % CNT_MOD;
        total_cnt++; if (resolved_count !== CNT_W'(mdl_resolved)) $display("FAIL flush_block_count got %0d exp %0d", resolved_count, mdl_resolved); else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        mdl_taken = 0; mdl_resolved = 0;
        total_cnt++; if (taken_count !== 0 || resolved_count !== 0) $display("FAIL clear tc=%0d rc=%0d exp 0/0", taken_count, resolved_count); else pass_cnt++;
        for (int i = 0; i < 16; i++) run_branch(32'h1000 + 32'(i * 4), 32'h00000463, 32'd3, 32'd3, 0, 1'b0);
        total_cnt++; if (taken_count !== 0) $display("FAIL taken_wrap got %0d exp 0", taken_count); else pass_cnt++;
    endtask

    task automatic test_clear_coincident();
        run_branch(32'h500, 32'h00000463, 32'd2, 32'd2, 0, 1'b0);
        run_branch(32'h500, 32'h00000463, 32'd2, 32'd2, 0, 1'b1);
        total_cnt++; if (taken_count !== 0 || resolved_count !== 0) $display("FAIL clear_win tc=%0d rc=%0d exp 0/0", taken_count, resolved_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_pc = 32'h600; req_instruction = 32'h00000463;
        req_source1 = 32'd4; req_source2 = 32'd4;
        tick();
        req_valid = 1'b0;
        tick();
        total_cnt++; if (redirect_valid !== 1'b1) $display("FAIL mid_redirect got %b exp 1", redirect_valid); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (redirect_valid !== 0 || flush !== 0 || redirect_pc !== 0 || req_ready !== 1 || taken_count !== 0 || resolved_count !== 0)
            $display("FAIL mid_reset rv=%b fl=%b pc=%h ready=%b tc=%0d rc=%0d exp 0/0/0/1/0/0", redirect_valid, flush, redirect_pc, req_ready, taken_count, resolved_count);
        else pass_cnt++;
        #3 rst = 1'b0;
        mdl_taken = 0; mdl_resolved = 0;
        tick();
        total_cnt++; if (redirect_valid !== 0 || flush !== 0 || stall !== 0) $display("FAIL post_reset rv=%b fl=%b st=%b exp 0/0/0", redirect_valid, flush, stall); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_taken_beq();
        test_not_taken_bne();
        test_signed_unsigned();
        test_back_to_back();
        test_flush_block();
        test_random();
        test_counter_wrap();
        test_clear_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
